data_memory_ws: RTL and testbench
=================================

Name: data_memory_ws

Overview:
Parametrised successor to the single-cycle data memory for the ARM pipeline's MEM stage. Byte-addressable little-endian RAM above a configurable base address. Supports byte, halfword and word accesses with optional sign extension. A configurable wait-state controller with a ready/stall handshake lets the pipeline freeze while an access is in flight. Misaligned and out-of-range accesses are flagged, never committed.

Parameters:
DEPTH_BYTES, 256, array size in bytes; power of two, >= 4
BASE_ADDR, 1024, byte address mapped to array index 0
WAIT_CYCLES, 1, extra wait states per access; legal range 0..15

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  synchronous active-high reset
MEM_R_EN  in  1  read request; held by pipeline until ready
MEM_W_EN  in  1  write request; held by pipeline until ready
address  in  32  byte address
storeValue  in  32  write data; byte in [7:0], halfword in [15:0]
size  in  2  00 byte, 01 halfword, 10 word, 11 reserved (treated as error)
sign_ext  in  1  reads only: 1 sign-extends byte/half, 0 zero-extends
memoryData  out  32  registered read data
ready  out  1  one-cycle pulse: access completed
stall  out  1  combinational freeze to hazard unit
error  out  1  registered, valid with ready: misaligned/out-of-range/illegal

Behaviour:
- Reset values: memoryData=0, ready=0, error=0, state=IDLE, counter=0. Array contents not cleared and are preserved across rst.
- idx = address - BASE_ADDR (32-bit unsigned wrap). Out of range iff idx >= DEPTH_BYTES, so addresses below BASE_ADDR are out of range.
- Misaligned: halfword with idx[0]=1; word with idx[1:0]!=0. size=11 is illegal.
- FSM states: IDLE, WAIT, DONE.
- IDLE: if MEM_R_EN|MEM_W_EN, latch idx, storeValue, size, sign_ext and op. If both enables are set, op=write.
  - WAIT_CYCLES=0: perform the access at this edge and go to DONE.
  - Otherwise load counter=WAIT_CYCLES and go to WAIT.
- WAIT: decrement counter each cycle. At the edge where counter==1, perform the access and go to DONE.
- Access:
  - If no fault, a write commits the sized bytes little-endian; other bytes are unchanged.
  - If no fault, a read loads memoryData with the extended value.
  - On fault: no array write, memoryData<=0, error<=1.
- DONE: ready=1 for exactly this cycle, then return to IDLE. A request is not accepted in DONE; the pipeline drops or advances its request here.
- Latency: ready asserts WAIT_CYCLES+1 cycles after the request is first seen in IDLE.
- Back-to-back throughput: one access per WAIT_CYCLES+2 cycles.
- stall = (MEM_R_EN|MEM_W_EN) & ~ready. stall is 0 when there is no request.
- memoryData holds its value until the next completed read. Writes do not change it. error is cleared on the cycle after DONE.
- Latched request fields are used during WAIT; input changes during WAIT are ignored.
- Reset mid-operation (WAIT or DONE): abort, discard the pending write, return to IDLE, no ready pulse.

Test Plan:
- WAIT_CYCLES=1: write word 0xDEADBEEF at 1024, then read word at 1024 -> ready pulses 2 cycles after each request, memoryData=0xDEADBEEF, stall high for 2 cycles per access, error=0.
- Byte write 0x80 at 1029, then read byte at 1029 with sign_ext=1 -> 0xFFFFFF80; with sign_ext=0 -> 0x00000080; other bytes of word 1028 unchanged.
- Halfword read at 1025 and word read at 1026 -> error=1 with ready, memoryData=0, array unchanged on a following aligned read.
- Read at 1023 and at 1024+DEPTH_BYTES -> error=1, no write committed for the matching writes.
- WAIT_CYCLES=0 instance: read at 1028 -> ready one cycle after the request; back-to-back requests complete every 2 cycles.
- Assert rst while in WAIT during a write of 0x12345678 at 1032 -> no ready pulse, state IDLE, subsequent read returns the prior contents of 1032.

Source files
------------

// File: rtl/data_memory_ws.sv
// Wait-stated, byte-addressable little-endian data memory for the MEM stage.
// Requests are latched in IDLE, serviced after WAIT_CYCLES, and completed with a one-cycle ready pulse.
//
// state | meaning
// IDLE  | waiting for MEM_R_EN/MEM_W_EN; request fields latched on acceptance
// WAIT  | counting down wait states; access performed when counter reaches 1
// DONE  | ready pulse; memoryData/error valid; no request accepted
module data_memory_ws #(
  parameter int          DEPTH_BYTES = 256,
  parameter logic [31:0] BASE_ADDR   = 32'd1024,
  parameter int          WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        MEM_R_EN,
  input  logic        MEM_W_EN,
  input  logic [31:0] address,
  input  logic [31:0] storeValue,
  input  logic [1:0]  size,
  input  logic        sign_ext,
  output logic [31:0] memoryData,
  output logic        ready,
  output logic        stall,
  output logic        error
);

  localparam int AW = $clog2(DEPTH_BYTES);

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  state_t      state, state_nxt;
  logic [3:0]  counter;
  logic [31:0] idx_q, sv_q;
  logic [1:0]  size_q;
  logic        sext_q, wr_q;
  logic        req, do_latch, do_access;

  logic [31:0] cur_idx, cur_sv;
  logic [1:0]  cur_size;
  logic        cur_sext, cur_wr, fault;
  logic [AW-1:0] i0, i1, i2, i3;
  logic [7:0]  b0, b1, b2, b3;
  logic [31:0] rd_val;

  logic [7:0] mem [DEPTH_BYTES];

  assign req   = MEM_R_EN | MEM_W_EN;
  assign ready = (state == DONE);
  assign stall = req & ~ready;

  // With zero wait states the access happens on the accepting edge, so use live inputs in IDLE.
  always_comb begin
    if (state == IDLE) begin
      cur_idx  = address - BASE_ADDR;
      cur_sv   = storeValue;
      cur_size = size;
      cur_sext = sign_ext;
      cur_wr   = MEM_W_EN;
    end else begin
      cur_idx  = idx_q;
      cur_sv   = sv_q;
      cur_size = size_q;
      cur_sext = sext_q;
      cur_wr   = wr_q;
    end
  end

  always_comb begin
    fault = (cur_idx >= 32'(DEPTH_BYTES));
    case (cur_size)
      2'b01:   fault = fault | cur_idx[0];
      2'b10:   fault = fault | (cur_idx[1:0] != 2'b00);
      2'b11:   fault = 1'b1;
      default: ;
    endcase
  end

  assign i0 = cur_idx[AW-1:0];
  assign i1 = i0 + AW'(1);
  assign i2 = i0 + AW'(2);
  assign i3 = i0 + AW'(3);
  assign b0 = mem[i0];
  assign b1 = mem[i1];
  assign b2 = mem[i2];
  assign b3 = mem[i3];

  always_comb begin
    case (cur_size)
      2'b00:   rd_val = {{24{cur_sext & b0[7]}}, b0};
      2'b01:   rd_val = {{16{cur_sext & b1[7]}}, b1, b0};
      default: rd_val = {b3, b2, b1, b0};
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    do_latch  = 1'b0;
    do_access = 1'b0;
    case (state)
      IDLE: begin
        if (req) begin
          do_latch = 1'b1;
          if (WAIT_CYCLES == 0) begin
            do_access = 1'b1;
            state_nxt = DONE;
          end else begin
            state_nxt = WAIT;
          end
        end
      end
      WAIT: begin
        if (counter == 4'd1) begin
          do_access = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      counter    <= 4'd0;
      memoryData <= 32'd0;
      error      <= 1'b0;
      idx_q      <= 32'd0;
      sv_q       <= 32'd0;
      size_q     <= 2'b00;
      sext_q     <= 1'b0;
      wr_q       <= 1'b0;
    end else begin
      if (do_latch) begin
        idx_q   <= cur_idx;
        sv_q    <= cur_sv;
        size_q  <= cur_size;
        sext_q  <= cur_sext;
        wr_q    <= cur_wr;
        counter <= 4'(WAIT_CYCLES);
      end else if (state == WAIT) begin
        counter <= counter - 4'd1;
      end
      if (do_access) begin
        if (fault) begin
          memoryData <= 32'd0;
          error      <= 1'b1;
        end else if (!cur_wr) begin
          memoryData <= rd_val;
        end
      end else if (state == DONE) begin
        error <= 1'b0;
      end
    end
  end

  // Array contents survive reset; the rst gate drops a write that is aborted on its access edge.
  always_ff @(posedge clk) begin
    if (!rst && do_access && cur_wr && !fault) begin
      mem[i0] <= cur_sv[7:0];
      if (cur_size != 2'b00) mem[i1] <= cur_sv[15:8];
      if (cur_size == 2'b10) begin
        mem[i2] <= cur_sv[23:16];
        mem[i3] <= cur_sv[31:24];
      end
    end
  end

endmodule

// File: tb/tb_data_memory_ws.sv
// Scoreboarded bench for data_memory_ws: one zero-wait and one one-wait instance
// driven in turn, checked every cycle against a byte-array reference model.
module tb_data_memory_ws;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [1:0]        r_en = '0, w_en = '0, se = '0;
  logic [1:0]        rdy, st, er;
  logic [1:0][31:0]  addr_s = '0, sv_s = '0, md_s;
  logic [1:0][1:0]   sz_s = '0;

  // Instance index equals its wait-state count.
  data_memory_ws #(.DEPTH_BYTES(256), .BASE_ADDR(32'd1024), .WAIT_CYCLES(0)) u_w0 (
    .clk(clk), .rst(rst), .MEM_R_EN(r_en[0]), .MEM_W_EN(w_en[0]), .address(addr_s[0]),
    .storeValue(sv_s[0]), .size(sz_s[0]), .sign_ext(se[0]), .memoryData(md_s[0]),
    .ready(rdy[0]), .stall(st[0]), .error(er[0]));

  data_memory_ws #(.DEPTH_BYTES(256), .BASE_ADDR(32'd1024), .WAIT_CYCLES(1)) u_w1 (
    .clk(clk), .rst(rst), .MEM_R_EN(r_en[1]), .MEM_W_EN(w_en[1]), .address(addr_s[1]),
    .storeValue(sv_s[1]), .size(sz_s[1]), .sign_ext(se[1]), .memoryData(md_s[1]),
    .ready(rdy[1]), .stall(st[1]), .error(er[1]));

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          d;
    int          rcyc;
    logic [31:0] md;
    logic        err;
  } exp_t;

  exp_t        q[$];
  logic [7:0]  mm[2][256];
  logic [31:0] md_m[2];
  logic [31:0] hold[2];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference: result of one access computed directly from the addressing and sizing rules.
  task automatic model(input int d, input logic wr, input logic [31:0] a, input logic [31:0] sv,
                       input logic [1:0] sz, input logic sx, output logic [31:0] md, output logic err);
    logic [31:0] idx;
    logic [63:0] val;
    int          n;
    idx = a - 32'd1024;
    n   = 1 << sz;
    err = (idx >= 256) || (sz == 2'd3) || (sz == 2'd1 && idx % 2 != 0) || (sz == 2'd2 && idx % 4 != 0);
    if (err) begin
      md = 32'd0;
    end else if (wr) begin
      for (int k = 0; k < n; k++) mm[d][idx + k] = 8'((sv >> (8 * k)) & 32'hFF);
      md = md_m[d];
    end else begin
      val = 64'd0;
      for (int k = 0; k < n; k++) val = val | (64'(mm[d][idx + k]) << (8 * k));
      if (sx && n < 4 && val[8 * n - 1]) val = val | ~((64'd1 << (8 * n)) - 64'd1);
      md = val[31:0];
    end
    md_m[d] = md;
  endtask

  task automatic access(input int d, input logic rd, input logic wr, input logic [31:0] a,
                        input logic [31:0] sv, input logic [1:0] sz, input logic sx, output int rc);
    logic [31:0] md;
    logic        err;
    logic        got;
    @(negedge clk);
    r_en[d] = rd; w_en[d] = wr; addr_s[d] = a; sv_s[d] = sv; sz_s[d] = sz; se[d] = sx;
    model(d, wr, a, sv, sz, sx, md, err);
    q.push_back('{d, cyc + d + 1, md, err});
    got = 1'b0;
    rc  = cyc;
    for (int n = 0; n < 20 && !got; n++) begin
      @(posedge clk);
      #1;
      if (rdy[d]) begin
        got = 1'b1;
        rc  = cyc;
      end else begin
        // Fields must be ignored once the request is latched.
        addr_s[d] = $urandom; sv_s[d] = $urandom; sz_s[d] = 2'($urandom); se[d] = 1'($urandom);
      end
    end
    chk($sformatf("ready_seen d%0d", d), 32'(got), 32'd1);
    @(negedge clk);
    r_en[d] = 1'b0; w_en[d] = 1'b0;
  endtask

  // Monitor: ready timing, stall, error, and held read data every cycle.
  always @(posedge clk) begin
    #1;
    for (int d = 0; d < 2; d++) begin
      if (rst) begin
        chk($sformatf("rst_ready d%0d", d), 32'(rdy[d]), 32'd0);
        chk($sformatf("rst_error d%0d", d), 32'(er[d]), 32'd0);
        chk($sformatf("rst_data d%0d", d), md_s[d], 32'd0);
        hold[d] = 32'd0;
      end else begin
        logic  exp_rdy;
        exp_t  it;
        exp_rdy = (q.size() > 0) && (q[0].d == d) && (q[0].rcyc == cyc);
        chk($sformatf("ready d%0d", d), 32'(rdy[d]), 32'(exp_rdy));
        chk($sformatf("stall d%0d", d), 32'(st[d]), 32'((r_en[d] | w_en[d]) & ~exp_rdy));
        if (exp_rdy) begin
          it = q.pop_front();
          chk($sformatf("error d%0d", d), 32'(er[d]), 32'(it.err));
          hold[d] = it.md;
        end else begin
          chk($sformatf("error_idle d%0d", d), 32'(er[d]), 32'd0);
        end
        chk($sformatf("data d%0d", d), md_s[d], hold[d]);
      end
    end
  end

  initial begin
    int          rc, rc_prev, op;
    logic [31:0] a, saved;
    md_m[0] = 32'd0;
    md_m[1] = 32'd0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    for (int d = 0; d < 2; d++)
      for (int i = 0; i < 64; i++)
        access(d, 1'b0, 1'b1, 32'd1024 + 32'(4 * i), $urandom, 2'd2, 1'b0, rc);

    access(1, 1'b0, 1'b1, 32'd1024, 32'hDEADBEEF, 2'd2, 1'b0, rc);
    access(1, 1'b1, 1'b0, 32'd1024, 32'h0, 2'd2, 1'b0, rc);
    chk("word_read", md_s[1], 32'hDEADBEEF);
    access(1, 1'b0, 1'b1, 32'd1029, 32'h00000080, 2'd0, 1'b0, rc);
    access(1, 1'b1, 1'b0, 32'd1029, 32'h0, 2'd0, 1'b1, rc);
    chk("byte_sext", md_s[1], 32'hFFFFFF80);
    access(1, 1'b1, 1'b0, 32'd1029, 32'h0, 2'd0, 1'b0, rc);
    chk("byte_zext", md_s[1], 32'h00000080);
    access(1, 1'b1, 1'b0, 32'd1028, 32'h0, 2'd2, 1'b0, rc);
    access(1, 1'b1, 1'b0, 32'd1025, 32'h0, 2'd1, 1'b0, rc);
    chk("misaligned_half_data", md_s[1], 32'd0);
    access(1, 1'b1, 1'b0, 32'd1026, 32'h0, 2'd2, 1'b0, rc);
    access(1, 1'b1, 1'b0, 32'd1024, 32'h0, 2'd2, 1'b0, rc);
    chk("after_fault_read", md_s[1], 32'hDEADBEEF);
    access(1, 1'b1, 1'b0, 32'd1023, 32'h0, 2'd0, 1'b0, rc);
    access(1, 1'b1, 1'b0, 32'd1280, 32'h0, 2'd0, 1'b0, rc);
    access(1, 1'b0, 1'b1, 32'd1023, 32'h55, 2'd0, 1'b0, rc);
    access(1, 1'b0, 1'b1, 32'd1280, 32'h55, 2'd0, 1'b0, rc);
    access(1, 1'b1, 1'b1, 32'd1040, 32'hCAFEF00D, 2'd2, 1'b0, rc);
    access(1, 1'b1, 1'b0, 32'd1040, 32'h0, 2'd2, 1'b0, rc);
    chk("both_en_writes", md_s[1], 32'hCAFEF00D);
    access(1, 1'b1, 1'b0, 32'd1024, 32'h0, 2'd3, 1'b0, rc);

    // Back-to-back throughput: one access per WAIT_CYCLES+2 cycles.
    for (int d = 0; d < 2; d++) begin
      access(d, 1'b1, 1'b0, 32'd1028, 32'h0, 2'd2, 1'b0, rc_prev);
      for (int i = 0; i < 3; i++) begin
        access(d, 1'b1, 1'b0, 32'd1028 + 32'(4 * i), 32'h0, 2'd2, 1'b0, rc);
        chk($sformatf("throughput d%0d", d), 32'(rc - rc_prev), 32'(d + 2));
        rc_prev = rc;
      end
    end

    // Reset while a write sits in WAIT: it must be discarded.
    saved = {mm[1][11], mm[1][10], mm[1][9], mm[1][8]};
    @(negedge clk);
    w_en[1] = 1'b1; addr_s[1] = 32'd1032; sv_s[1] = 32'h12345678; sz_s[1] = 2'd2;
    @(negedge clk);
    rst = 1'b1; w_en[1] = 1'b0;
    md_m[0] = 32'd0;
    md_m[1] = 32'd0;
    @(negedge clk);
    rst = 1'b0;
    access(1, 1'b1, 1'b0, 32'd1032, 32'h0, 2'd2, 1'b0, rc);
    chk("reset_abort_write", md_s[1], saved);

    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 150; i++) begin
        case ($urandom_range(0, 9))
          0:       a = 32'd1024 - 32'($urandom_range(1, 8));
          1:       a = 32'd1280 + 32'($urandom_range(0, 8));
          2:       a = $urandom;
          default: a = 32'd1024 + 32'($urandom_range(0, 255));
        endcase
        op = $urandom_range(1, 3);
        access(d, 1'(op & 1), 1'(op >> 1), a, $urandom, 2'($urandom_range(0, 3)), 1'($urandom), rc);
      end
    end

    repeat (3) @(negedge clk);
    chk("queue_drained", 32'(q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
